// File: rtl/swivm_uart_tx_pkg.sv
// Shared definitions for the SwiVM character-output UART: FSM state encoding
// and default baud constants.
package swivm_uart_tx_pkg;

    typedef enum logic [1:0] {
        UTX_IDLE  = 2'd0,
        UTX_START = 2'd1,
        UTX_DATA  = 2'd2,
        UTX_STOP  = 2'd3
    } utx_state_t;

    // 12 MHz / 115200 baud
    localparam int UART_CLKS_PER_BIT = 104;

    // Width of the baud counter; wide enough for any practical divider.
    localparam int BAUD_W = 16;

endpackage

// File: rtl/swivm_byte_fifo.sv
// Synchronous show-ahead byte FIFO: rd_data always presents the head entry
// while empty is low; writes to a full FIFO and reads from an empty one are ignored.
module swivm_byte_fifo #(
    parameter int AW = 4,
    parameter int W  = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_en,
    input  logic [W-1:0]  wr_data,
    input  logic          rd_en,
    output logic [W-1:0]  rd_data,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty
);

    localparam logic [AW:0] DEPTH = (AW+1)'(2**AW);

    logic [W-1:0]  mem [2**AW];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          wr_ok;
    logic          rd_ok;

    assign full    = (count == DEPTH);
    assign empty   = (count == '0);
    assign wr_ok   = wr_en & ~full;
    assign rd_ok   = rd_en & ~empty;
    assign rd_data = mem[rd_ptr];

    // Storage is not reset; the pointers and count alone define validity.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/swivm_uart_tx.sv
// SwiVM character-output sink: buffers outbyte strobes in a FIFO and sends
// each byte as 8N1 serial on txd, LSB first, with back-to-back frames contiguous.
module swivm_uart_tx
    import swivm_uart_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
    parameter int FIFO_AW      = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       outbyte,
    input  logic             outbyte_valid,
    output logic             txd,
    output logic             busy,
    output logic             overflow,
    output logic [FIFO_AW:0] fifo_count
);

    localparam logic [BAUD_W-1:0] BIT_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    utx_state_t        state_q, state_d;
    logic [BAUD_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic [7:0]        sh_q, sh_d;
    logic              txd_q, txd_d;
    logic              busy_q, busy_d;
    logic              overflow_q;

    logic              push;
    logic              pop;
    logic              bit_end;
    logic [7:0]        fifo_rd_data;
    logic [FIFO_AW:0]  fifo_cnt;
    logic [FIFO_AW:0]  cnt_next;
    logic              fifo_full;
    logic              fifo_empty;

    // A push into a full FIFO is dropped even when the FSM pops on the same edge.
    assign push    = outbyte_valid & ~fifo_full;
    assign bit_end = (bit_cnt_q == BIT_LAST);

    swivm_byte_fifo #(
        .AW (FIFO_AW),
        .W  (8)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (push),
        .wr_data (outbyte),
        .rd_en   (pop),
        .rd_data (fifo_rd_data),
        .count   (fifo_cnt),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        bit_idx_d = bit_idx_q;
        sh_d      = sh_q;
        txd_d     = txd_q;
        pop       = 1'b0;
        case (state_q)
            UTX_IDLE: begin
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    sh_d      = fifo_rd_data;
                    txd_d     = 1'b0;
                    bit_cnt_d = '0;
                    state_d   = UTX_START;
                end
            end
            UTX_START: begin
                if (bit_end) begin
                    bit_cnt_d = '0;
                    bit_idx_d = '0;
                    txd_d     = sh_q[0];
                    state_d   = UTX_DATA;
                end else begin
                    bit_cnt_d = bit_cnt_q + BAUD_W'(1);
                end
            end
            UTX_DATA: begin
                if (bit_end) begin
                    bit_cnt_d = '0;
                    if (bit_idx_q == 3'd7) begin
                        txd_d   = 1'b1;
                        state_d = UTX_STOP;
                    end else begin
                        sh_d      = {1'b0, sh_q[7:1]};
                        txd_d     = sh_q[1];
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + BAUD_W'(1);
                end
            end
            UTX_STOP: begin
                if (bit_end) begin
                    bit_cnt_d = '0;
                    // Chain straight into the next start bit so frames abut.
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        sh_d    = fifo_rd_data;
                        txd_d   = 1'b0;
                        state_d = UTX_START;
                    end else begin
                        state_d = UTX_IDLE;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + BAUD_W'(1);
                end
            end
            default: begin
                state_d = UTX_IDLE;
                txd_d   = 1'b1;
            end
        endcase
    end

    // Post-edge FIFO occupancy, so busy lines up with the registered state.
    always_comb begin
        cnt_next = fifo_cnt;
        case ({push, pop})
            2'b10:   cnt_next = fifo_cnt + (FIFO_AW+1)'(1);
            2'b01:   cnt_next = fifo_cnt - (FIFO_AW+1)'(1);
            default: cnt_next = fifo_cnt;
        endcase
        busy_d = (state_d != UTX_IDLE) | (cnt_next != '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= UTX_IDLE;
            bit_cnt_q  <= '0;
            bit_idx_q  <= '0;
            sh_q       <= '0;
            txd_q      <= 1'b1;
            busy_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            bit_idx_q  <= bit_idx_d;
            sh_q       <= sh_d;
            txd_q      <= txd_d;
            busy_q     <= busy_d;
            overflow_q <= overflow_q | (outbyte_valid & fifo_full);
        end
    end

    assign txd        = txd_q;
    assign busy       = busy_q;
    assign overflow   = overflow_q;
    assign fifo_count = fifo_cnt;

endmodule

// File: tb/tb_swivm_uart_tx.sv
// Bench for swivm_uart_tx: a queue-and-frame-position reference model checks
// every cycle, a mid-bit line decoder checks the bytes on txd.
module tb_swivm_uart_tx;

    localparam int CPB   = 4;
    localparam int AW    = 2;
    localparam int DEPTH = 4;
    localparam int FRAME = 10 * CPB;

    // ---------------- clock / reset / DUT ----------------
    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [7:0]    outbyte = 8'h00;
    logic          outbyte_valid = 1'b0;
    logic          txd;
    logic          busy;
    logic          overflow;
    logic [AW:0]   fifo_count;

    always #5 clk = ~clk;

    swivm_uart_tx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_AW      (AW)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .outbyte       (outbyte),
        .outbyte_valid (outbyte_valid),
        .txd           (txd),
        .busy          (busy),
        .overflow      (overflow),
        .fifo_count    (fifo_count)
    );

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    bit started = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    // Queue of waiting bytes plus position within the current frame (-1 = line idle).
    logic [7:0] mdl_q[$];
    int         mdl_pos = -1;
    logic [7:0] mdl_cur = 8'h00;
    logic       mdl_ovf = 1'b0;
    logic [7:0] exp_q[$];
    bit         rx_abort = 1'b0;

    always @(posedge clk) begin
        int pre;
        bit do_pop;
        cyc++;
        started = 1'b1;
        if (reset) begin
            mdl_q.delete();
            exp_q.delete();
            mdl_pos  = -1;
            mdl_ovf  = 1'b0;
            rx_abort = 1'b1;
        end else begin
            pre    = mdl_q.size();
            do_pop = (pre > 0) && (mdl_pos < 0 || mdl_pos == FRAME - 1);
            if (do_pop) begin
                mdl_cur = mdl_q.pop_front();
                exp_q.push_back(mdl_cur);
                mdl_pos = 0;
            end else if (mdl_pos == FRAME - 1) begin
                mdl_pos = -1;
            end else if (mdl_pos >= 0) begin
                mdl_pos++;
            end
            if (outbyte_valid) begin
                if (pre < DEPTH) mdl_q.push_back(outbyte);
                else             mdl_ovf = 1'b1;
            end
        end
    end

    function automatic logic exp_txd();
        int slot;
        if (mdl_pos < 0) return 1'b1;
        slot = mdl_pos / CPB;
        if (slot == 0) return 1'b0;
        if (slot == 9) return 1'b1;
        return mdl_cur[slot-1];
    endfunction

    always @(negedge clk) begin
        if (started) begin
            chk("txd", {31'b0, txd}, {31'b0, exp_txd()});
            chk("busy", {31'b0, busy}, {31'b0, (mdl_pos >= 0) || (mdl_q.size() > 0)});
            chk("overflow", {31'b0, overflow}, {31'b0, mdl_ovf});
            chk("fifo_count", 32'(fifo_count), 32'(mdl_q.size()));
        end
    end

    // ---------------- line decoder (mid-bit sampling) ----------------
    bit         rx_active = 1'b0;
    int         rx_t = 0;
    logic [7:0] rx_byte = 8'h00;
    int         rx_frames = 0;
    logic [7:0] rx_log[$];

    always @(negedge clk) begin
        int slot;
        if (started) begin
            if (rx_abort) begin
                rx_abort  = 1'b0;
                rx_active = 1'b0;
            end else if (!rx_active) begin
                if (txd === 1'b0) begin
                    rx_active = 1'b1;
                    rx_t      = 0;
                end
            end else begin
                rx_t++;
            end
            if (rx_active && (rx_t % CPB) == CPB / 2) begin
                slot = rx_t / CPB;
                if (slot == 0) begin
                    chk("rx_start_bit", {31'b0, txd}, 32'd0);
                end else if (slot <= 8) begin
                    rx_byte[slot-1] = txd;
                end else begin
                    chk("rx_stop_bit", {31'b0, txd}, 32'd1);
                    rx_frames++;
                    rx_log.push_back(rx_byte);
                    if (exp_q.size() == 0) chk("rx_unexpected_frame", 32'(rx_byte), 32'hffff_ffff);
                    else                   chk("rx_byte", 32'(rx_byte), 32'(exp_q.pop_front()));
                    rx_active = 1'b0;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic push(input logic [7:0] b);
        outbyte       = b;
        outbyte_valid = 1'b1;
        @(negedge clk);
        outbyte_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        repeat (n) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        while (busy === 1'b1 && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (busy !== 1'b0) chk("idle_timeout", {31'b0, busy}, 32'd0);
    endtask

    task automatic wait_cyc(input int target);
        int k = 0;
        while (cyc < target && k < 1000) begin
            @(negedge clk);
            k++;
        end
        chk("wait_cyc_reached", 32'(cyc), 32'(target));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;
        int f0;
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_txd", {31'b0, txd}, 32'd1);
            chk("rst_busy", {31'b0, busy}, 32'd0);
            chk("rst_overflow", {31'b0, overflow}, 32'd0);
            chk("rst_count", 32'(fifo_count), 32'd0);
        end
        reset = 1'b0;
        idle(3);

        // single byte 'A'
        f0 = rx_frames;
        push(8'h41);
        n = cyc;
        chk("single_txd_before", {31'b0, txd}, 32'd1);
        @(negedge clk);
        chk("single_txd_fall", {31'b0, txd}, 32'd0);
        wait_idle(200);
        chk("single_busy_fall", 32'(cyc - n), 32'd41);
        chk("single_frames", 32'(rx_frames - f0), 32'd1);
        chk("single_byte", 32'(rx_log[$]), 32'h41);
        idle(5);

        // back-to-back "Hi"
        f0 = rx_frames;
        push(8'h48);
        n = cyc;
        push(8'h69);
        wait_idle(400);
        chk("b2b_span", 32'(cyc - n), 32'd81);
        chk("b2b_frames", 32'(rx_frames - f0), 32'd2);
        chk("b2b_byte0", 32'(rx_log[$-1]), 32'h48);
        chk("b2b_byte1", 32'(rx_log[$]), 32'h69);
        idle(5);

        // overflow: six consecutive pushes into a 4-deep FIFO
        chk("ovf_pre", {31'b0, overflow}, 32'd0);
        f0 = rx_frames;
        for (int i = 0; i < 6; i++) push(8'($urandom_range(0, 255)));
        chk("ovf_set", {31'b0, overflow}, 32'd1);
        chk("ovf_count", 32'(fifo_count), 32'd4);
        wait_idle(600);
        chk("ovf_frames", 32'(rx_frames - f0), 32'd5);
        chk("ovf_sticky", {31'b0, overflow}, 32'd1);

        // push into full FIFO on the same edge the FSM pops
        do_reset(2);
        chk("fp_ovf_clear", {31'b0, overflow}, 32'd0);
        f0 = rx_frames;
        push(8'($urandom_range(0, 255)));
        n = cyc;
        for (int i = 0; i < 4; i++) push(8'($urandom_range(0, 255)));
        wait_cyc(n + 40);
        chk("fp_count_pre", 32'(fifo_count), 32'd4);
        push(8'hEE);
        chk("fp_count_post", 32'(fifo_count), 32'd3);
        chk("fp_ovf", {31'b0, overflow}, 32'd1);
        wait_idle(600);
        chk("fp_frames", 32'(rx_frames - f0), 32'd5);

        // reset during data bit 3
        do_reset(1);
        idle(2);
        push(8'h5A);
        n = cyc;
        push(8'hC3);
        wait_cyc(n + 18);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("midrst_txd", {31'b0, txd}, 32'd1);
        chk("midrst_count", 32'(fifo_count), 32'd0);
        chk("midrst_busy", {31'b0, busy}, 32'd0);
        f0 = rx_frames;
        idle(100);
        chk("midrst_no_frames", 32'(rx_frames - f0), 32'd0);

        // random traffic, including bursts that overrun the FIFO
        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 9))
                0:       for (int j = 0; j < int'($urandom_range(1, 6)); j++) push(8'($urandom_range(0, 255)));
                1, 2:    push(8'($urandom_range(0, 255)));
                default: idle($urandom_range(1, 8));
            endcase
        end
        wait_idle(2000);
        idle(CPB * 2);
        chk("rand_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
